// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: fetch states, instruction field positions, default widths
package cpu_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        FETCH_W0 = 2'd0,
        FETCH_W1 = 2'd1,
        VALID    = 2'd2
    } fetch_state_e;

    // Instruction word: [15:14] mode, [13:12] byte, [11:8] opcode, [7:5] op1, [4:2] op2, [1:0] optype
    localparam int MODE_HI   = 15;
    localparam int MODE_LO   = 14;
    localparam int BYTE_HI   = 13;
    localparam int BYTE_LO   = 12;
    localparam int OPCODE_HI = 11;
    localparam int OPCODE_LO = 8;
    localparam int OP1_HI    = 7;
    localparam int OP1_LO    = 5;
    localparam int OP2_HI    = 4;
    localparam int OP2_LO    = 2;
    localparam int OPTYPE_HI = 1;
    localparam int OPTYPE_LO = 0;

    localparam logic [1:0] BYTE_TWO_WORD = 2'b10;

endpackage

// File: rtl/ifetch_len_decode.sv
// rtl/ifetch_len_decode.sv - instruction length decode from the byte field of the first word
module ifetch_len_decode
    import cpu_pkg::*;
(
    input  logic [1:0] byte_field,
    output logic       two_word
);

    assign two_word = (byte_field == BYTE_TWO_WORD);

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end; IFETCH_PREFETCH_EN enables next-pc prefetch in VALID
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ADDR_W-1:0] rom_addr_in,
    input  logic [DATA_W-1:0] rom_data_in,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [DATA_W-1:0] ins_word0,
    output logic [DATA_W-1:0] ins_word1,
    output logic              ins_two_word,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam logic [1:0] ST_FETCH_W0 = FETCH_W0;
    localparam logic [1:0] ST_FETCH_W1 = FETCH_W1;
    localparam logic [1:0] ST_VALID    = VALID;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_p1;
    logic [ADDR_W-1:0] pc_p2;
    logic [ADDR_W-1:0] next_pc;
    logic              two_word_in;
    logic              tag_w0;
    logic              tag_w1;

    ifetch_len_decode u_len_decode (
        .byte_field (rom_data_in[BYTE_HI:BYTE_LO]),
        .two_word   (two_word_in)
    );

    // All pc arithmetic wraps modulo 2^ADDR_W
    assign pc_p1   = pc + ADDR_W'(1);
    assign pc_p2   = pc + ADDR_W'(2);
    assign next_pc = ins_two_word ? pc_p2 : pc_p1;

    // The ROM echoes the address it sampled; only a matching echo carries the word we asked for
    assign tag_w0 = (rom_addr_in == pc);
    assign tag_w1 = (rom_addr_in == pc_p1);

    assign ins_valid = (state == ST_VALID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_FETCH_W0;
            pc           <= RESET_PC;
            rom_addr     <= RESET_PC;
            ins_word0    <= '0;
            ins_word1    <= '0;
            ins_two_word <= 1'b0;
            ins_pc       <= '0;
        end else if (redirect) begin
            // A coincident handshake has already been seen by the decoder; just restart here
            state    <= ST_FETCH_W0;
            pc       <= redirect_pc;
            rom_addr <= redirect_pc;
        end else begin
            case (state)
                ST_FETCH_W0: begin
                    if (tag_w0) begin
                        ins_word0 <= rom_data_in;
                        ins_pc    <= pc;
                        if (two_word_in) begin
                            rom_addr <= pc_p1;
                            state    <= ST_FETCH_W1;
                        end else begin
                            ins_word1    <= '0;
                            ins_two_word <= 1'b0;
                            state        <= ST_VALID;
`ifdef IFETCH_PREFETCH_EN
                            rom_addr     <= pc_p1;
`endif
                        end
                    end
                end
                ST_FETCH_W1: begin
                    if (tag_w1) begin
                        ins_word1    <= rom_data_in;
                        ins_two_word <= 1'b1;
                        state        <= ST_VALID;
`ifdef IFETCH_PREFETCH_EN
                        rom_addr     <= pc_p2;
`endif
                    end
                end
                ST_VALID: begin
                    if (ins_ready) begin
                        pc       <= next_pc;
                        rom_addr <= next_pc;
                        state    <= ST_FETCH_W0;
                    end
                end
                default: state <= ST_FETCH_W0;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit with a registered static ROM model
module tb_ifetch_unit;

`ifdef IFETCH_PREFETCH_EN
    localparam bit PREF = 1'b1;
    localparam int TPUT = 2;
`else
    localparam bit PREF = 1'b0;
    localparam int TPUT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic [15:0] rom_addr_in;
    logic [15:0] rom_data_in;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins_word0;
    logic [15:0] ins_word1;
    logic        ins_two_word;
    logic [15:0] ins_pc;
    logic        redirect;
    logic [15:0] redirect_pc;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rom_addr     (rom_addr),
        .rom_addr_in  (rom_addr_in),
        .rom_data_in  (rom_data_in),
        .ins_valid    (ins_valid),
        .ins_ready    (ins_ready),
        .ins_word0    (ins_word0),
        .ins_word1    (ins_word1),
        .ins_two_word (ins_two_word),
        .ins_pc       (ins_pc),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    logic [15:0] rom [0:65535];

    // Registered ROM: echo and data of the address sampled at the previous edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_in <= 16'hFFFF;
            rom_data_in <= 16'h0000;
        end else begin
            rom_addr_in <= rom_addr;
            rom_data_in <= rom[rom_addr];
        end
    end

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] w0;
        logic [15:0] w1;
        logic        two;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_hs  = 0;
    int   prev_hs  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] pc);
        exp_t        e;
        logic [15:0] pc1;
        pc1   = pc + 16'd1;
        e.pc  = pc;
        e.w0  = rom[pc];
        e.two = (rom[pc][13:12] == 2'b10);
        e.w1  = e.two ? rom[pc1] : 16'h0000;
        sb.push_back(e);
    endtask

    // Every accepted instruction is popped here and compared
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ins_valid && ins_ready) begin
            prev_hs = last_hs;
            last_hs = cyc;
            if (sb.size() == 0) begin
                check_val("unexpected_ins_pc", {16'h0, ins_pc}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check_val("sb_pc",   {16'h0, ins_pc},      {16'h0, e.pc});
                check_val("sb_w0",   {16'h0, ins_word0},   {16'h0, e.w0});
                check_val("sb_w1",   {16'h0, ins_word1},   {16'h0, e.w1});
                check_val("sb_two",  {31'h0, ins_two_word}, {31'h0, e.two});
            end
        end
    end

    task automatic wait_valid();
        for (int i = 0; i < 20 && !ins_valid; i++) begin
            @(posedge clk); #1;
        end
        check_val("valid_seen", {31'h0, ins_valid}, 32'h1);
    endtask

    task automatic take_one();
        wait_valid();
        ins_ready = 1'b1;
        @(posedge clk); #1;
        ins_ready = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [15:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        @(posedge clk); #1;
        redirect    = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = {4'h0, 12'(i)};
        rom[16'h0000] = 16'h1B5C;
        rom[16'h0003] = 16'hADCC;
        rom[16'h0004] = 16'h8449;
        rom[16'h0006] = 16'h2A06;
        rom[16'hFFFF] = 16'h2ABC;

        rst_n       = 1'b0;
        ins_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        repeat (3) @(negedge clk);
        check_val("rst_valid", {31'h0, ins_valid},    32'h0);
        check_val("rst_addr",  {16'h0, rom_addr},     32'h0);
        check_val("rst_pc",    {16'h0, ins_pc},       32'h0);
        check_val("rst_w0",    {16'h0, ins_word0},    32'h0);
        check_val("rst_w1",    {16'h0, ins_word1},    32'h0);
        check_val("rst_two",   {31'h0, ins_two_word}, 32'h0);

        // First fetch after reset: valid after the second edge
        rst_n     = 1'b1;
        ins_ready = 1'b1;
        push_exp(16'h0000);
        @(posedge clk); #1;
        check_val("lat_edge1_valid", {31'h0, ins_valid}, 32'h0);
        @(posedge clk); #1;
        check_val("lat_edge2_valid", {31'h0, ins_valid}, 32'h1);
        @(posedge clk); #1;
        check_val("after_hs_valid", {31'h0, ins_valid}, 32'h0);
        check_val("after_hs_addr",  {16'h0, rom_addr},  32'h1);
        ins_ready = 1'b0;

        // One-word, one-word, then two-word LDA at 3
        push_exp(16'h0001); take_one();
        push_exp(16'h0002); take_one();
        push_exp(16'h0003); take_one();
        check_val("two_word_next_addr", {16'h0, rom_addr}, 32'h5);

        // Stall in VALID for 5 cycles
        push_exp(16'h0005);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check_val("stall_valid", {31'h0, ins_valid}, 32'h1);
            check_val("stall_pc",    {16'h0, ins_pc},    32'h5);
            check_val("stall_w0",    {16'h0, ins_word0}, {16'h0, rom[5]});
            check_val("stall_addr",  {16'h0, rom_addr},  PREF ? 32'h6 : 32'h5);
            @(posedge clk); #1;
        end
        ins_ready = 1'b1;
        @(posedge clk); #1;
        ins_ready = 1'b0;
        check_val("stall_adv_addr", {16'h0, rom_addr}, 32'h6);

        // Redirect while the two-word instruction at 6 waits for its second word
        if (!PREF) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check_val("w1_addr", {16'h0, rom_addr}, 32'h7);
        pulse_redirect(16'h0007);
        push_exp(16'h0007);
        take_one();

        // Redirect coincident with the handshake of the instruction at 5
        pulse_redirect(16'h0005);
        push_exp(16'h0005);
        wait_valid();
        ins_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        @(posedge clk); #1;
        ins_ready = 1'b0;
        redirect  = 1'b0;
        check_val("redir_hs_addr", {16'h0, rom_addr}, 32'hFFFF);

        // Two-word instruction at FFFF takes word1 from 0000
        push_exp(16'hFFFF);
        take_one();
        check_val("wrap_next_addr", {16'h0, rom_addr}, 32'h1);
        push_exp(16'h0001);
        take_one();

        // Back-to-back one-word throughput with ins_ready held high
        pulse_redirect(16'h0020);
        for (int a = 16'h20; a < 16'h26; a++) push_exp(16'(a));
        ins_ready = 1'b1;
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        ins_ready = 1'b0;
        check_val("tput_drain", sb.size(), 32'h0);
        check_val("tput_interval", last_hs - prev_hs, TPUT);

        repeat (4) @(posedge clk);
        #1;
        check_val("final_sb_empty", sb.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
